// File: rtl/arm_alu_mc.sv
// Multi-cycle ARM data-processing ALU: single-cycle DP opcodes plus shift-add MUL/MLA.
// Holds one operation in flight behind valid/ready handshakes on both sides.
module arm_alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_mode,
    input  logic [3:0]       alu_op_sel,
    input  logic [WIDTH-1:0] alu_op1,
    input  logic [WIDTH-1:0] alu_op2,
    input  logic [WIDTH-1:0] alu_op3,
    input  logic [3:0]       flags_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       flags_out,
    output logic             result_wr
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] MODE_MUL = 2'd1;
    localparam logic [1:0] MODE_MLA = 2'd2;
    localparam logic [1:0] MODE_RSV = 2'd3;

    localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_is_mul;

    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_op1;
    logic [WIDTH-1:0]   r_op2;
    logic [1:0]         r_cv;
    logic [WIDTH-1:0]   r_alu_out;
    logic [3:0]         r_flags;
    logic               r_wr;
    logic               r_out_valid;

    logic [WIDTH-1:0]   w_add_x;
    logic [WIDTH-1:0]   w_add_y;
    logic               w_add_cin;
    logic               w_is_arith;
    logic [WIDTH-1:0]   w_logic;
    logic [WIDTH:0]     w_add_sum;
    logic [WIDTH-1:0]   w_dp_res;
    logic               w_dp_c;
    logic               w_dp_v;
    logic               w_dp_wr;
    logic [WIDTH-1:0]   w_cap_res;
    logic [3:0]         w_cap_flags;
    logic               w_cap_wr;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_acc_nxt;

    assign w_is_mul = (alu_mode == MODE_MUL) || (alu_mode == MODE_MLA);

    // Adder operand steering: subtracts become x + ~y + cin so C is NOT borrow
    always_comb begin
        w_add_x    = alu_op1;
        w_add_y    = alu_op2;
        w_add_cin  = 1'b0;
        w_is_arith = 1'b1;
        case (alu_op_sel)
            OP_SUB, OP_CMP: begin
                w_add_y   = ~alu_op2;
                w_add_cin = 1'b1;
            end
            OP_RSB: begin
                w_add_x   = alu_op2;
                w_add_y   = ~alu_op1;
                w_add_cin = 1'b1;
            end
            OP_ADD, OP_CMN: w_add_cin = 1'b0;
            OP_ADC:         w_add_cin = flags_in[1];
            OP_SBC: begin
                w_add_y   = ~alu_op2;
                w_add_cin = flags_in[1];
            end
            OP_RSC: begin
                w_add_x   = alu_op2;
                w_add_y   = ~alu_op1;
                w_add_cin = flags_in[1];
            end
            default: w_is_arith = 1'b0;
        endcase
    end

    always_comb begin
        w_logic = '0;
        case (alu_op_sel)
            OP_AND, OP_TST: w_logic = alu_op1 & alu_op2;
            OP_EOR, OP_TEQ: w_logic = alu_op1 ^ alu_op2;
            OP_ORR:         w_logic = alu_op1 | alu_op2;
            OP_MOV:         w_logic = alu_op2;
            OP_BIC:         w_logic = alu_op1 & ~alu_op2;
            OP_MVN:         w_logic = ~alu_op2;
            default:        w_logic = '0;
        endcase
    end

    assign w_add_sum = {1'b0, w_add_x} + {1'b0, w_add_y} + {{WIDTH{1'b0}}, w_add_cin};
    assign w_dp_res  = w_is_arith ? w_add_sum[WIDTH-1:0] : w_logic;
    assign w_dp_c    = w_is_arith ? w_add_sum[WIDTH] : flags_in[1];
    assign w_dp_v    = w_is_arith ? ((w_add_x[WIDTH-1] == w_add_y[WIDTH-1]) &&
                                     (w_dp_res[WIDTH-1] != w_add_x[WIDTH-1]))
                                  : flags_in[0];
    assign w_dp_wr   = (alu_op_sel[3:2] != 2'b10);

    // Reserved mode completes as a no-op that passes the flags through untouched
    always_comb begin
        w_cap_res   = w_dp_res;
        w_cap_flags = {w_dp_res[WIDTH-1], (w_dp_res == '0), w_dp_c, w_dp_v};
        w_cap_wr    = w_dp_wr;
        if (alu_mode == MODE_RSV) begin
            w_cap_res   = '0;
            w_cap_flags = flags_in;
            w_cap_wr    = 1'b0;
        end
    end

    assign w_addend  = r_op2[r_count] ? (r_op1 << r_count) : '0;
    assign w_acc_nxt = r_acc + w_addend;

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready = 1'b1;
            S_DONE:  w_in_ready = out_ready;
            default: w_in_ready = 1'b0;
        endcase
        if (flush || !reset_n) begin
            w_in_ready = 1'b0;
        end
        w_accept = in_valid && w_in_ready;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? S_MUL : S_DONE;
                end else if ((r_state == S_DONE) && out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL: begin
                if (r_count == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, multiply iteration and result registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_count     <= '0;
            r_acc       <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_cv        <= '0;
            r_alu_out   <= '0;
            r_flags     <= '0;
            r_wr        <= 1'b0;
        end else begin
            r_out_valid <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                if (w_is_mul) begin
                    r_op1   <= alu_op1;
                    r_op2   <= alu_op2;
                    r_acc   <= (alu_mode == MODE_MLA) ? alu_op3 : '0;
                    r_count <= '0;
                    r_cv    <= flags_in[1:0];
                end else begin
                    r_alu_out <= w_cap_res;
                    r_flags   <= w_cap_flags;
                    r_wr      <= w_cap_wr;
                end
            end else if ((r_state == S_MUL) && !flush) begin
                r_acc   <= w_acc_nxt;
                r_count <= r_count + CNT_W'(1);
                if (r_count == CNT_LAST) begin
                    r_alu_out <= w_acc_nxt;
                    r_flags   <= {w_acc_nxt[WIDTH-1], (w_acc_nxt == '0), r_cv};
                    r_wr      <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign alu_out   = r_alu_out;
    assign flags_out = r_flags;
    assign result_wr = r_wr;

endmodule
